// File: rtl/audio_cfg_pkg.sv
// Shared types and constants for the audio codec power-up sequencer.
package audio_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POWERUP_WAIT,
    S_LOAD,
    S_REQ,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } cfg_state_e;

  // Codec control register addresses (7-bit)
  localparam logic [6:0] REG_LINVOL = 7'h00;
  localparam logic [6:0] REG_RINVOL = 7'h01;
  localparam logic [6:0] REG_LHPOUT = 7'h02;
  localparam logic [6:0] REG_RHPOUT = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWRDN  = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  // One table entry: 7-bit register address over 9-bit register value
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } cfg_entry_t;

  function automatic cfg_entry_t mk_entry(input logic [6:0] r, input logic [8:0] d);
    return cfg_entry_t'({r, d});
  endfunction

endpackage

// File: rtl/audio_codec_config_rom.sv
// Fixed power-up register table for the codec; unused slots read as zero.
module audio_codec_config_rom
  import audio_cfg_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] word
);

  // Table lookup: reset first, then power, volumes, paths, format, activate
  always_comb begin
    word = '0;
    case (index)
      4'd0:    word = mk_entry(REG_RESET,  9'h000);
      4'd1:    word = mk_entry(REG_PWRDN,  9'h000);
      4'd2:    word = mk_entry(REG_LINVOL, 9'h017);
      4'd3:    word = mk_entry(REG_RINVOL, 9'h017);
      4'd4:    word = mk_entry(REG_APATH,  9'h012);
      4'd5:    word = mk_entry(REG_DPATH,  9'h000);
      4'd6:    word = mk_entry(REG_IFACE,  9'h042);
      4'd7:    word = mk_entry(REG_SRATE,  9'h000);
      4'd8:    word = mk_entry(REG_ACTIVE, 9'h001);
      4'd9:    word = mk_entry(REG_LHPOUT, 9'h079);
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/audio_codec_config.sv
// Power-up configuration sequencer: walks the codec register table and feeds
// each entry to the i2c write engine, with power-up wait, gaps, retries and
// handshake timeouts.
module audio_codec_config
  import audio_cfg_pkg::*;
#(
  parameter logic [7:0] DEVICE_ADDR    = 8'h34,
  parameter int         NUM_REGS       = 10,
  parameter int         POWERUP_CYCLES = 4000,
  parameter int         GAP_CYCLES     = 8,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       clk_400kHz,
  input  logic       rst,
  input  logic       start_cfg,
  output logic       i2c_req,
  output logic [7:0] i2c_address,
  output logic [7:0] i2c_data_0,
  output logic [7:0] i2c_data_1,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [3:0] cfg_index
);

  localparam int PW_W  = $clog2(POWERUP_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RT_W  = $clog2(MAX_RETRY) + 1;

  // Counters are loaded with N-1 so each wait state lasts exactly N cycles
  localparam logic [PW_W-1:0]  PW_INIT  = PW_W'(POWERUP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_INIT  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_REGS - 1);

  cfg_state_e       state, state_n;
  logic [PW_W-1:0]  pw_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [RT_W-1:0]  retry;
  logic [3:0]       index;
  logic             last_ok;
  logic             xfer_ok, xfer_fail;
  logic             entering;
  logic [15:0]      rom_word;

  audio_codec_config_rom u_rom (
    .index (index),
    .word  (rom_word)
  );

  // State register
  always_ff @(posedge clk_400kHz) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state, attempt outcome and state-decoded outputs
  always_comb begin
    state_n   = state;
    xfer_ok   = 1'b0;
    xfer_fail = 1'b0;
    i2c_req   = 1'b0;
    cfg_busy  = 1'b1;
    cfg_done  = 1'b0;
    cfg_error = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_busy = 1'b0;
        if (start_cfg) state_n = S_POWERUP_WAIT;
      end
      S_DONE: begin
        cfg_busy = 1'b0;
        cfg_done = 1'b1;
        if (start_cfg) state_n = S_POWERUP_WAIT;
      end
      S_ERROR: begin
        cfg_busy  = 1'b0;
        cfg_error = 1'b1;
        if (start_cfg) state_n = S_POWERUP_WAIT;
      end
      S_POWERUP_WAIT: if (pw_cnt == '0) state_n = S_LOAD;
      S_LOAD:         state_n = S_REQ;
      S_REQ: begin
        i2c_req = 1'b1;
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        i2c_req = 1'b1;
        // a done without a visible busy counts as busy and done together
        if (i2c_done) begin
          xfer_ok   = !i2c_nack;
          xfer_fail = i2c_nack;
        end else if (i2c_busy) begin
          state_n = S_WAIT_DONE;
        end else if (to_cnt == '0) begin
          xfer_fail = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i2c_done) begin
          xfer_ok   = !i2c_nack;
          xfer_fail = i2c_nack;
        end else if (to_cnt == '0) begin
          xfer_fail = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0)
          state_n = (last_ok && index == LAST_IDX) ? S_DONE : S_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
    if (xfer_ok)   state_n = S_GAP;
    if (xfer_fail) state_n = (retry < RT_MAX) ? S_GAP : S_ERROR;
  end

  assign entering = (state_n != state);

  // Wait counters: load on entry to their state, count down to zero and stop
  always_ff @(posedge clk_400kHz) begin
    if (rst) begin
      pw_cnt  <= '0;
      gap_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (entering && state_n == S_POWERUP_WAIT) pw_cnt <= PW_INIT;
      else if (pw_cnt != '0)                     pw_cnt <= pw_cnt - 1'b1;

      if (entering && state_n == S_GAP) gap_cnt <= GAP_INIT;
      else if (gap_cnt != '0)           gap_cnt <= gap_cnt - 1'b1;

      if (entering && (state_n == S_WAIT_BUSY || state_n == S_WAIT_DONE))
        to_cnt <= TO_INIT;
      else if (to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
    end
  end

  // Table position, retry bookkeeping and registered transfer bytes
  always_ff @(posedge clk_400kHz) begin
    if (rst) begin
      index       <= '0;
      retry       <= '0;
      last_ok     <= 1'b0;
      i2c_address <= '0;
      i2c_data_0  <= '0;
      i2c_data_1  <= '0;
    end else begin
      if (entering && state_n == S_POWERUP_WAIT) begin
        index   <= '0;
        retry   <= '0;
        last_ok <= 1'b0;
      end
      if (state == S_LOAD) begin
        i2c_address <= DEVICE_ADDR;
        i2c_data_0  <= rom_word[15:8];
        i2c_data_1  <= rom_word[7:0];
      end
      if (xfer_ok) begin
        retry   <= '0;
        last_ok <= 1'b1;
      end
      if (xfer_fail) begin
        last_ok <= 1'b0;
        if (retry < RT_MAX) retry <= retry + 1'b1;
      end
      // advance only after a successful write that is not the last entry
      if (state == S_GAP && state_n == S_LOAD && last_ok)
        index <= index + 1'b1;
    end
  end

  assign cfg_index = index;

endmodule

// File: tb/tb_audio_codec_config.sv
// Bench for the codec configuration sequencer: i2c engine model, transfer
// scoreboard, table of end-to-end scenarios and a few hand-written sequences.
module tb_audio_codec_config;

  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst, start_cfg;
  logic       i2c_req, i2c_busy, i2c_done, i2c_nack;
  logic [7:0] i2c_address, i2c_data_0, i2c_data_1;
  logic       cfg_busy, cfg_done, cfg_error;
  logic [3:0] cfg_index;

  audio_codec_config dut (
    .clk_400kHz  (clk),
    .rst         (rst),
    .start_cfg   (start_cfg),
    .i2c_req     (i2c_req),
    .i2c_address (i2c_address),
    .i2c_data_0  (i2c_data_0),
    .i2c_data_1  (i2c_data_1),
    .i2c_busy    (i2c_busy),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .cfg_index   (cfg_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] d0;
    logic [7:0] d1;
  } xfer_t;

  typedef struct {
    logic [6:0] reg_a;
    logic [8:0] data;
  } rom_vec_t;

  typedef struct {
    int fail_idx;
    int fail_cnt;
    bit never_busy;
    bit exp_done;
    bit exp_err;
    int exp_idx;
    int exp_att;
  } scen_t;

  xfer_t    sb[$];
  rom_vec_t rom_tbl[10];
  scen_t    scen[4];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int n_att = 0;
  int last_done_cyc = -1;
  int nack_idx = -1, nack_left = 0;
  bit never_busy = 0;
  bit eng_active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // i2c engine model: busy 2 cycles after req, done 20 cycles later
  initial begin
    xfer_t e;
    int    hold;
    bit    req_q;
    i2c_busy = 0; i2c_done = 0; i2c_nack = 0; req_q = 0;
    forever begin
      @(negedge clk);
      if (i2c_req && !req_q && !rst) begin
        eng_active = 1;
        n_att++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
          e.idx = 0; e.d0 = 0; e.d1 = 0;
        end else begin
          e = sb.pop_front();
          chk("xfer_idx", cfg_index, e.idx);
          chk("xfer_addr", i2c_address, 8'h34);
          chk("xfer_d0", i2c_data_0, e.d0);
          chk("xfer_d1", i2c_data_1, e.d1);
          if (last_done_cyc >= 0) chk_rng("gap", cyc - last_done_cyc, 8, 20);
        end
        if (never_busy) begin
          hold = 0;
          while (i2c_req && hold < 200) begin
            @(negedge clk);
            hold++;
          end
          // one REQ cycle plus the WAIT_BUSY timeout window
          chk_rng("req_hold", hold, 64, 65);
        end else begin
          repeat (2) @(negedge clk);
          i2c_busy = 1;
          repeat (20) @(negedge clk);
          i2c_busy = 0;
          i2c_done = 1;
          i2c_nack = (int'(e.idx) == nack_idx && nack_left > 0);
          if (i2c_nack) nack_left--;
          last_done_cyc = cyc;
          @(negedge clk);
          i2c_done = 0;
          i2c_nack = 0;
        end
        eng_active = 0;
      end
      req_q = i2c_req;
    end
  end

  task automatic push_expected(input int fi, input int fc);
    xfer_t e;
    int    reps;
    for (int i = 0; i < 10; i++) begin
      reps = 1;
      if (i == fi) reps = (fc > MAXR) ? MAXR + 1 : fc + 1;
      e.idx = 4'(i);
      e.d0  = {rom_tbl[i].reg_a, rom_tbl[i].data[8]};
      e.d1  = rom_tbl[i].data[7:0];
      for (int r = 0; r < reps; r++) sb.push_back(e);
      if (i == fi && fc > MAXR) break;
    end
  endtask

  task automatic pulse_start();
    start_cfg = 1;
    @(negedge clk);
    start_cfg = 0;
  endtask

  task automatic wait_eng_idle();
    int n = 0;
    while (eng_active && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("eng_idle_bound", n < 200, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    wait_eng_idle();
    sb.delete();
    n_att = 0;
    last_done_cyc = -1;
  endtask

  task automatic check_powerup();
    int n = 0;
    while (!i2c_req && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk_rng("powerup_wait", n, 4000, 4003);
  endtask

  task automatic wait_end();
    int n = 0;
    while (cfg_busy && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_end_bound", n < 30000, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   i2c_req, 0);
    chk({tag, "_busy"},  cfg_busy, 0);
    chk({tag, "_done"},  cfg_done, 0);
    chk({tag, "_err"},   cfg_error, 0);
    chk({tag, "_index"}, cfg_index, 0);
    chk({tag, "_addr"},  i2c_address, 0);
    chk({tag, "_d0"},    i2c_data_0, 0);
    chk({tag, "_d1"},    i2c_data_1, 0);
  endtask

  initial begin
    int n;
    int att0;
    rst = 1; start_cfg = 0;

    rom_tbl[0] = '{7'h0F, 9'h000};
    rom_tbl[1] = '{7'h06, 9'h000};
    rom_tbl[2] = '{7'h00, 9'h017};
    rom_tbl[3] = '{7'h01, 9'h017};
    rom_tbl[4] = '{7'h04, 9'h012};
    rom_tbl[5] = '{7'h05, 9'h000};
    rom_tbl[6] = '{7'h07, 9'h042};
    rom_tbl[7] = '{7'h08, 9'h000};
    rom_tbl[8] = '{7'h09, 9'h001};
    rom_tbl[9] = '{7'h02, 9'h079};

    //           fail_idx cnt nb done err idx att
    scen[0] = '{-1, 0,  0, 1, 0, 9, 10};  // nominal
    scen[1] = '{ 3, 1,  0, 1, 0, 9, 11};  // one NACK at index 3
    scen[2] = '{ 5, 99, 0, 0, 1, 5, 9};   // persistent NACK at index 5
    scen[3] = '{ 0, 99, 1, 0, 1, 0, 4};   // engine never raises busy

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    for (int s = 0; s < 4; s++) begin
      do_reset();
      never_busy = scen[s].never_busy;
      nack_idx   = scen[s].fail_idx;
      nack_left  = scen[s].fail_cnt;
      push_expected(scen[s].fail_idx, scen[s].fail_cnt);
      pulse_start();
      check_powerup();
      wait_end();
      chk($sformatf("s%0d_done", s),  cfg_done,  scen[s].exp_done);
      chk($sformatf("s%0d_err", s),   cfg_error, scen[s].exp_err);
      chk($sformatf("s%0d_index", s), cfg_index, scen[s].exp_idx);
      wait_eng_idle();
      att0 = n_att;
      repeat (100) @(negedge clk);
      chk($sformatf("s%0d_attempts", s), n_att, scen[s].exp_att);
      chk($sformatf("s%0d_no_req_after", s), n_att - att0, 0);
      chk($sformatf("s%0d_sb_left", s), sb.size(), 0);
    end

    // Restart straight out of ERROR with a healthy engine
    never_busy = 0; nack_idx = -1; nack_left = 0;
    n_att = 0; last_done_cyc = -1;
    push_expected(-1, 0);
    pulse_start();
    chk("restart_err_clr", cfg_error, 0);
    chk("restart_busy", cfg_busy, 1);
    chk("restart_index", cfg_index, 0);
    check_powerup();
    wait_end();
    chk("restart_done", cfg_done, 1);
    wait_eng_idle();
    chk("restart_attempts", n_att, 10);

    // Reset while index 4 is in WAIT_DONE
    do_reset();
    push_expected(-1, 0);
    pulse_start();
    n = 0;
    while ((n_att < 5 || !i2c_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_bound", n < 20000, 1);
    repeat (3) @(negedge clk);
    chk("midrst_pre_index", cfg_index, 4);
    rst = 1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 0;
    wait_eng_idle();
    sb.delete();
    n_att = 0; last_done_cyc = -1;

    // Restart from index 0, with start pulses in WAIT_DONE and in GAP
    push_expected(-1, 0);
    pulse_start();
    check_powerup();
    n = 0;
    while ((n_att < 3 || !i2c_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("poke_wd_bound", n < 20000, 1);
    pulse_start();
    chk("poke_wd_busy", cfg_busy, 1);
    chk("poke_wd_index", cfg_index, 2);
    n = 0;
    while ((n_att < 7 || eng_active) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("poke_gap_bound", n < 20000, 1);
    pulse_start();
    chk("poke_gap_busy", cfg_busy, 1);
    chk("poke_gap_index", cfg_index, 6);
    wait_end();
    chk("poke_done", cfg_done, 1);
    chk("poke_index", cfg_index, 9);
    wait_eng_idle();
    chk("poke_attempts", n_att, 10);
    chk("poke_sb_left", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/audio_codec_config.md
Name: audio_codec_config

Overview:
- Power-up configuration sequencer for the audio codec.
- Walks a fixed table of NUM_REGS codec register writes and hands each one to the existing i2c write engine as one address byte plus two data bytes, using a req/busy/done handshake.
- Handles the power-up delay, inter-write gaps, NACK retries and handshake timeouts.
- Sits between the top-level audio capture block and the i2c engine, in the clk_400kHz domain.

Parameters:
- DEVICE_ADDR, 8'h34, i2c write address byte of the codec (7-bit 0x1A plus W bit).
- NUM_REGS, 10, number of table entries; range 1..16.
- POWERUP_CYCLES, 4000, clk_400kHz cycles waited before the first write (10 ms).
- GAP_CYCLES, 8, idle cycles between the done of one write and the req of the next.
- MAX_RETRY, 3, extra attempts per entry after a failure (NACK or timeout).
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT_BUSY or in WAIT_DONE before the attempt counts as failed.

Ports:
- clk_400kHz, in, 1, sequencer clock, shared with the i2c engine.
- rst, in, 1, synchronous active-high reset.
- start_cfg, in, 1, one-cycle pulse that starts or restarts configuration; ignored unless in IDLE, DONE or ERROR.
- i2c_req, out, 1, write request to the engine, held until busy is seen.
- i2c_address, out, 8, address byte; always DEVICE_ADDR.
- i2c_data_0, out, 8, first data byte, {reg[6:0], data[8]}.
- i2c_data_1, out, 8, second data byte, data[7:0].
- i2c_busy, in, 1, engine is transferring.
- i2c_done, in, 1, one-cycle pulse at the end of a transfer.
- i2c_nack, in, 1, valid only in the cycle i2c_done is high; 1 means the slave did not acknowledge.
- cfg_busy, out, 1, high in every state except IDLE, DONE and ERROR.
- cfg_done, out, 1, high and sticky in DONE.
- cfg_error, out, 1, high and sticky in ERROR.
- cfg_index, out, 4, table index of the current or failing entry.

Behaviour:
- Reset: state IDLE; all outputs 0; counters cleared. A reset asserted mid-transfer drops i2c_req in the next cycle, and nothing is retried.
- Data outputs are registered. They are loaded from the ROM in LOAD and held stable from LOAD until the next LOAD.
- IDLE: on start_cfg go to POWERUP_WAIT, with index=0, retry=0 and the counter loaded.
- POWERUP_WAIT: count POWERUP_CYCLES cycles, then go to LOAD. A restart from DONE or ERROR also passes through POWERUP_WAIT.
- LOAD: register the ROM word for index into data_0 and data_1, then go to REQ.
- REQ: i2c_req=1; go to WAIT_BUSY in the same cycle.
- WAIT_BUSY:
  - Hold i2c_req=1 until i2c_busy=1; then i2c_req=0 and go to WAIT_DONE.
  - If i2c_done arrives while busy was never seen, treat it as both events at once.
  - After TIMEOUT_CYCLES without busy, the attempt fails.
- WAIT_DONE:
  - On i2c_done with nack=0: retry=0, go to GAP.
  - On i2c_done with nack=1: the attempt fails.
  - After TIMEOUT_CYCLES without done, the attempt fails.
- Failure handling:
  - If retry<MAX_RETRY: retry++, go to GAP, then re-issue the same index via LOAD.
  - Otherwise go to ERROR, and cfg_index holds the failing index.
- GAP: wait GAP_CYCLES cycles.
  - After a success: if index==NUM_REGS-1 go to DONE, else index++ and go to LOAD.
  - After a failure: go to LOAD with the index unchanged.
- DONE and ERROR: terminal. start_cfg clears cfg_done and cfg_error, clears index and retry, and goes to POWERUP_WAIT.
- start_cfg while cfg_busy=1 is ignored.
- Counter widths: each counter is $clog2 of its maximum parameter plus 1. Counters load on state entry and terminate at 0, with no wrap-around.
- Timeout counters restart on entry to WAIT_BUSY and on entry to WAIT_DONE.

Decomposition:
- Package audio_cfg_pkg holds:
  - the state enum;
  - the codec register address constants (LINVOL=0x00, RINVOL=0x01, LHPOUT=0x02, RHPOUT=0x03, APATH=0x04, DPATH=0x05, PWRDN=0x06, IFACE=0x07, SRATE=0x08, ACTIVE=0x09, RESET=0x0F);
  - a 16-bit entry format {reg[6:0], data[8:0]}.
- Sub-module audio_codec_config_rom: a combinational 4-bit index to 16-bit word lookup.
  - Entries in order: RESET=0x000, PWRDN=0x000, LINVOL=0x017, RINVOL=0x017, APATH=0x012, DPATH=0x000, IFACE=0x042, SRATE=0x000, ACTIVE=0x001, LHPOUT=0x079.
  - Unused indices return 16'h0000.

Test Plan:
- Nominal run: rst, then start_cfg, with an engine model that acks (busy 2 cycles after req, done 20 cycles later) -> no req before 4000 cycles; then 10 transfers. Transfer 0 carries addr 0x34, d0=0x1E, d1=0x00; transfer 8 carries d0=0x12, d1=0x01. Gaps are at least 8 cycles; cfg_done=1 after the last transfer.
- Single NACK at index 3 -> index 3 is re-sent once with identical bytes (d0=0x02, d1=0x17), the sequence completes, and cfg_error stays 0.
- Persistent NACK at index 5 -> exactly 4 attempts at index 5; then cfg_error=1, cfg_index=5, and no further req.
- Engine never asserts busy -> req is held 64 cycles, followed by 3 retries and then ERROR with cfg_index=0. A subsequent start_cfg clears cfg_error and restarts with the power-up wait.
- Reset mid-transfer at index 4 during WAIT_DONE -> the next cycle shows req=0, cfg_busy=0 and all outputs 0. start_cfg then restarts from index 0.
- start_cfg pulses during WAIT_DONE and during GAP -> no effect on the sequence or on the index progression.
